// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the control unit and the multiply/divide unit.
// The control unit is the master; the arithmetic unit is the slave.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a_in, b_in,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a_in, b_in,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) and divide (restoring on magnitudes)
// producing HI/LO; one iteration per clock edge, results registered in FINISH.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic          clock,
  input  logic          reset,
  mult_div_unit_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_FINISH} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic               q1_q, q1_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               op_q, op_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH:0]     booth_sum;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_diff;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  // Booth add is done one bit wider so the most-negative multiplicand cannot overflow
  always_comb begin
    unique case ({acc_lo_q[0], q1_q})
      2'b01:   booth_sum = {acc_hi_q[WIDTH-1], acc_hi_q} + {mcand_q[WIDTH-1], mcand_q};
      2'b10:   booth_sum = {acc_hi_q[WIDTH-1], acc_hi_q} - {mcand_q[WIDTH-1], mcand_q};
      default: booth_sum = {acc_hi_q[WIDTH-1], acc_hi_q};
    endcase
    rem_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, mcand_q};
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    q1_d       = q1_q;
    mcand_d    = mcand_q;
    op_d       = op_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    dz_d       = dz_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d     = bus.op;
          cnt_d    = '0;
          acc_hi_d = '0;
          q1_d     = 1'b0;
          dz_d     = 1'b0;
          if (bus.op) begin
            mcand_d   = magnitude(bus.b_in);
            acc_lo_d  = magnitude(bus.a_in);
            neg_quo_d = bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1];
            neg_rem_d = bus.a_in[WIDTH-1];
            if (bus.b_in == '0) begin
              dz_d    = 1'b1;
              state_d = S_FINISH;
            end else begin
              state_d = S_DIV;
            end
          end else begin
            mcand_d  = bus.a_in;
            acc_lo_d = bus.b_in;
            state_d  = S_MULT;
          end
        end
      end
      S_MULT: begin
        acc_hi_d = booth_sum[WIDTH:1];
        acc_lo_d = {booth_sum[0], acc_lo_q[WIDTH-1:1]};
        q1_d     = acc_lo_q[0];
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = S_FINISH;
      end
      S_DIV: begin
        if (rem_diff[WIDTH]) begin
          acc_hi_d = rem_shift[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_hi_d = rem_diff[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = S_FINISH;
      end
      S_FINISH: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (dz_q) begin
          div_zero_d = 1'b1;
        end else if (op_q) begin
          lo_d = neg_quo_q ? (~acc_lo_q + 1'b1) : acc_lo_q;
          hi_d = neg_rem_q ? (~acc_hi_q + 1'b1) : acc_hi_q;
        end else begin
          hi_d = acc_hi_q;
          lo_d = acc_lo_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      q1_q       <= 1'b0;
      mcand_q    <= '0;
      op_q       <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      q1_q       <= q1_d;
      mcand_q    <= mcand_d;
      op_q       <= op_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      dz_q       <= dz_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  // The divide-by-zero FINISH cycle is not an operation in progress
  assign bus.busy     = (state_q == S_MULT) || (state_q == S_DIV) ||
                        ((state_q == S_FINISH) && !dz_q);
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: table of operations with hand-computed
// HI/LO and latency, plus busy-restart, back-to-back and mid-operation reset sequences.
module tb_mult_div_unit;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
    int          bcnt;
  } vec_t;

  vec_t vecs[11];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  // Called at a negedge; start is seen by the next rising edge (edge k).
  // lat counts negedges after edge k until done is seen (33 => after edge k+33).
  task automatic run_op(input logic op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                        input int inj, input bit chain,
                        output int lat, output logic [31:0] h, output logic [31:0] l,
                        output logic dz, output int bcnt, output logic busy_done,
                        output logic dz_early);
    int n;
    bus.start = 1'b1; bus.op = op_v; bus.a_in = a_v; bus.b_in = b_v;
    @(negedge clock);
    bus.start = 1'b0;
    n = 0; bcnt = 0; dz_early = 1'b0;
    while (!bus.done && n < 80) begin
      if (bus.busy) bcnt++;
      if (bus.div_zero) dz_early = 1'b1;
      if (inj > 0 && n == inj) begin
        bus.start = 1'b1; bus.op = 1'b1; bus.a_in = 32'd9; bus.b_in = 32'd0;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clock);
      n++;
    end
    bus.start = 1'b0;
    lat = n; h = bus.hi; l = bus.lo; dz = bus.div_zero; busy_done = bus.busy;
    if (!chain) begin
      @(negedge clock);
      chk("done_pulse_width", {31'd0, bus.done}, 32'd0);
      chk("div_zero_pulse_width", {31'd0, bus.div_zero}, 32'd0);
    end
  endtask

  initial begin
    int          lat, bcnt, seen;
    logic [31:0] h, l;
    logic        dz, bd, dze;

    vecs[0]  = '{1'b0, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33, 33};
    vecs[1]  = '{1'b0, 32'h7FFFFFFF,  32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 33, 33};
    vecs[2]  = '{1'b0, 32'h80000000,  32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33, 33};
    vecs[3]  = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 33, 33};
    vecs[4]  = '{1'b0, 32'h80000000,  32'h7FFFFFFF, 32'hC0000000, 32'h80000000, 1'b0, 33, 33};
    vecs[5]  = '{1'b1, 32'd5,         32'd0,        32'hC0000000, 32'h80000000, 1'b1, 1,  0};
    vecs[6]  = '{1'b1, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, 33};
    vecs[7]  = '{1'b1, 32'd100,       32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 1'b0, 33, 33};
    vecs[8]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33, 33};
    vecs[9]  = '{1'b1, 32'd7,         32'd3,        32'h00000001, 32'h00000002, 1'b0, 33, 33};
    vecs[10] = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 1'b0, 33, 33};

    bus.start = 1'b0; bus.op = 1'b0; bus.a_in = '0; bus.b_in = '0;
    repeat (3) @(negedge clock);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    chk("reset_div_zero", {31'd0, bus.div_zero}, 32'd0);
    chk("reset_hi", bus.hi, 32'd0);
    chk("reset_lo", bus.lo, 32'd0);
    reset = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, 1'b0, lat, h, l, dz, bcnt, bd, dze);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_hi", i), h, vecs[i].hi);
      chk($sformatf("vec%0d_lo", i), l, vecs[i].lo);
      chk($sformatf("vec%0d_div_zero", i), {31'd0, dz}, {31'd0, vecs[i].dz});
      chk($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'(vecs[i].bcnt));
      chk($sformatf("vec%0d_busy_with_done", i), {31'd0, bd}, 32'd0);
      chk($sformatf("vec%0d_div_zero_early", i), {31'd0, dze}, 32'd0);
    end

    // start (div 9/0) injected mid-multiply must be ignored
    run_op(1'b0, 32'd3, 32'd5, 10, 1'b0, lat, h, l, dz, bcnt, bd, dze);
    chk("ignore_start_latency", 32'(lat), 32'd33);
    chk("ignore_start_hi", h, 32'd0);
    chk("ignore_start_lo", l, 32'd15);
    chk("ignore_start_div_zero", {31'd0, dz | dze}, 32'd0);

    // start in the done cycle is accepted
    run_op(1'b0, 32'd3, 32'd5, 0, 1'b1, lat, h, l, dz, bcnt, bd, dze);
    chk("chain_first_lo", l, 32'd15);
    run_op(1'b1, 32'd100, 32'hFFFFFFF9, 0, 1'b0, lat, h, l, dz, bcnt, bd, dze);
    chk("chain_second_latency", 32'(lat), 32'd33);
    chk("chain_second_hi", h, 32'd2);
    chk("chain_second_lo", l, 32'hFFFFFFF2);

    // reset sampled at edge k+12 of a multiply
    bus.start = 1'b1; bus.op = 1'b0; bus.a_in = 32'd100; bus.b_in = 32'd200;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (11) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("midreset_busy", {31'd0, bus.busy}, 32'd0);
    chk("midreset_hi", bus.hi, 32'd0);
    chk("midreset_lo", bus.lo, 32'd0);
    reset = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.done || bus.busy) seen++;
      @(negedge clock);
    end
    chk("midreset_no_activity", 32'(seen), 32'd0);
    run_op(1'b0, 32'd6, 32'd7, 0, 1'b0, lat, h, l, dz, bcnt, bd, dze);
    chk("after_reset_latency", 32'(lat), 32'd33);
    chk("after_reset_hi", h, 32'd0);
    chk("after_reset_lo", l, 32'd42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
